// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Boot stage in front of the core's instruction memory. It receives
//            a length-prefixed program image over a valid/ready stream, writes
//            each instruction word into the IMEM write port, and holds the
//            core in reset until a complete image has been loaded.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - begin a new load (IDLE/DONE/ERR only)
//            in_valid/in_data/in_ready - input word stream
//            imem_we/imem_waddr/imem_wdata - IMEM write port (1-cycle latency)
//            core_rst        - core reset, low only in DONE
//            busy/done/error - status (LEN/LOAD/CHK, DONE, ERR)
//            word_count      - instruction words accepted in this load
// Config   : IMEM_BOOT_CHECKSUM_EN - adds a trailing XOR checksum word (CHK)
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int                  C_TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] C_MAX_LEN = DATA_WIDTH'(2 ** ADDR_WIDTH);
  localparam logic [C_TW-1:0]     C_TO_LAST = C_TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_LOAD = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,S_CHK = 3'd5
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_in_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic [ADDR_WIDTH:0]   r_len;
  logic [C_TW-1:0]       r_idle;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_xor;
`endif

  logic                  w_xfer;
  logic                  w_busy;
  logic                  w_timeout;
  logic                  w_last;
  logic                  w_nxt_busy;
  logic [ADDR_WIDTH:0]   w_wc_inc;

  assign w_xfer    = in_valid & r_in_ready;
  assign w_busy    = (r_state == S_LEN) || (r_state == S_LOAD)
`ifdef IMEM_BOOT_CHECKSUM_EN
                     || (r_state == S_CHK)
`endif
                     ;
  // A transfer in the final idle cycle wins over the timeout.
  assign w_timeout = w_busy && !w_xfer && (r_idle == C_TO_LAST);
  assign w_wc_inc  = r_word_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_last    = (w_wc_inc == r_len);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LEN;
      S_LEN: begin
        if (w_xfer) begin
          if (in_data > C_MAX_LEN)
            w_state_nxt = S_ERR;
          else if (in_data == '0)
`ifdef IMEM_BOOT_CHECKSUM_EN
            w_state_nxt = S_CHK;
`else
            w_state_nxt = S_DONE;
`endif
          else
            w_state_nxt = S_LOAD;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          if (w_last)
`ifdef IMEM_BOOT_CHECKSUM_EN
            w_state_nxt = S_CHK;
`else
            w_state_nxt = S_DONE;
`endif
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer)
          w_state_nxt = (in_data == r_xor) ? S_DONE : S_ERR;
        else if (w_timeout)
          w_state_nxt = S_ERR;
      end
`endif
      S_DONE, S_ERR: if (start) w_state_nxt = S_LEN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_nxt_busy = (w_state_nxt == S_LEN) || (w_state_nxt == S_LOAD)
`ifdef IMEM_BOOT_CHECKSUM_EN
                      || (w_state_nxt == S_CHK)
`endif
                      ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_word_count <= '0;
      r_len        <= '0;
      r_idle       <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      // Registered decode of the upcoming state, so in_ready never
      // depends on in_valid.
      r_in_ready <= w_nxt_busy;
      r_we       <= 1'b0;

      if (w_xfer && (r_state == S_LEN))
        r_len <= in_data[ADDR_WIDTH:0];

      if (w_xfer && (r_state == S_LOAD)) begin
        r_we         <= 1'b1;
        r_waddr      <= r_word_count[ADDR_WIDTH-1:0];
        r_wdata      <= in_data;
        r_word_count <= w_wc_inc;
      end

      if ((w_state_nxt == S_LEN) && (r_state != S_LEN))
        r_word_count <= '0;

      if (!w_busy || w_xfer)
        r_idle <= '0;
      else
        r_idle <= r_idle + {{(C_TW-1){1'b0}}, 1'b1};

`ifdef IMEM_BOOT_CHECKSUM_EN
      // Checksum covers the length word and every instruction word.
      if (w_xfer && (r_state == S_LEN))
        r_xor <= in_data;
      else if (w_xfer && (r_state == S_LOAD))
        r_xor <= r_xor ^ in_data;
`endif
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign word_count = r_word_count;
  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);
  assign core_rst   = (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Self-checking bench for imem_boot_loader. Expected IMEM writes
//            (address, data, cycle) are queued as words are accepted and a
//            monitor compares them against the write port. Status outputs
//            are compared against the image-level rules of the loader.
// Config   : IMEM_BOOT_CHECKSUM_EN - bench appends checksum words as well
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, imem_we, core_rst, busy, done, error;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic [AW:0]   word_count;

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .busy(busy), .done(done),
    .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            at;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            gap_max = 0;
  logic [DW-1:0] img [512];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every IMEM write must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(imem_waddr), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", 64'(imem_waddr), 64'(e.addr));
        chk("wdata", 64'(imem_wdata), 64'(e.data));
        chk("wcycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one word; random idle gaps (with ignored start pulses, since the
  // loader is busy) precede it. Queues the expected write when accepted.
  task automatic send_word(input logic [DW-1:0] w, input bit is_write,
                           input logic [AW-1:0] a);
    bit acc;
    bit ok;
    int gap;
    gap = $urandom_range(0, gap_max);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = ($urandom_range(0, 3) == 0);
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    ok       = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else if (is_write) exp_q.push_back('{addr: a, data: w, at: cyc});
  endtask

  // Load an image: length word len, instruction words img[0..len-1].
  task automatic load_image(input int len, input bit bad_chk);
    logic [DW-1:0] x;
    bit            too_big;
    bit            fail;
    too_big = (len > (1 << AW));
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_core_rst", 64'(core_rst), 64'd1);
    chk("start_wc", 64'(word_count), 64'd0);
    chk("start_err", 64'(error), 64'd0);
    send_word(DW'(len), 1'b0, '0);
    x = DW'(len);
    if (!too_big) begin
      for (int i = 0; i < len; i++) begin
        x = x ^ img[i];
        send_word(img[i], 1'b1, AW'(i));
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      send_word(bad_chk ? (x ^ 32'h1) : x, 1'b0, '0);
`endif
    end
    fail = too_big;
`ifdef IMEM_BOOT_CHECKSUM_EN
    fail = fail || bad_chk;
`endif
    @(negedge clk);
    chk("end_done", 64'(done), 64'(!fail));
    chk("end_error", 64'(error), 64'(fail));
    chk("end_core_rst", 64'(core_rst), 64'(fail));
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_ready", 64'(in_ready), 64'd0);
    chk("end_wc", 64'(word_count), too_big ? 64'd0 : 64'(len));
    // Stray valid words while finished must not be accepted or written.
    in_valid = 1'b1;
    in_data  = $urandom;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("stray_ready", 64'(in_ready), 64'd0);
    chk("stray_state", 64'(done), 64'(!fail));
  endtask

  initial begin
    int n;
    // Reset
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_waddr", 64'(imem_waddr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_status", 64'({busy, done, error}), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    rst = 1'b0;
    tick();

    // Fixed program, back-to-back then with gaps
    img[0] = 32'h20080005; img[1] = 32'h2009000A; img[2] = 32'h01095020;
    gap_max = 0;
    load_image(3, 1'b0);
    gap_max = 1;
    load_image(3, 1'b0);

    // Oversized length, then recovery
    load_image(32'h101, 1'b0);
    gap_max = 0;
    img[0] = 32'h12345678;
    load_image(1, 1'b0);

    // Timeout after 2 of 4 words
    pulse_start();
    send_word(32'd4, 1'b0, '0);
    send_word(32'hAAAA0000, 1'b1, 8'd0);
    send_word(32'hBBBB0001, 1'b1, 8'd1);
    repeat (TO - 1) tick();
    chk("to_not_yet", 64'(error), 64'd0);
    tick();
    chk("to_error", 64'(error), 64'd1);
    chk("to_core_rst", 64'(core_rst), 64'd1);
    chk("to_wc", 64'(word_count), 64'd2);

    // Reset mid-load after 1 of 4 words
    pulse_start();
    send_word(32'd4, 1'b0, '0);
    send_word(32'hCCCC0000, 1'b1, 8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_core_rst", 64'(core_rst), 64'd1);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    load_image(4, 1'b0);

    // Randomized images including empty and full-depth
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: n = 0;
        1: n = 1 << AW;
        2: n = (1 << AW) + 1 + int'($urandom_range(0, 1000));
        default: n = int'($urandom_range(1, 20));
      endcase
      gap_max = int'($urandom_range(0, 3));
      for (int i = 0; i < 512; i++) img[i] = $urandom;
      load_image(n, 1'b0);
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    gap_max = 0;
    img[0] = 32'hA; img[1] = 32'h5;
    load_image(2, 1'b0);
    load_image(2, 1'b1);
`endif

    repeat (4) tick();
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
